// File: rtl/fsm_seq_detect_pkg.sv
// Shared constants for the 1011 serial sequence detector.
// State width, state codes and the detected pattern.
package fsm_seq_detect_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4
  } state_t;

  localparam logic [STATE_W-1:0] PATTERN = 4'b1011;

endpackage

// File: rtl/fsm_seq_detect.sv
// Moore detector for serial pattern 1011 (MSB first) on x.
// Ports: clk, rst (sync, active-low), x in; y detect flag,
// ps1 registered state, ns1 combinational next state.
module fsm_seq_detect
  import fsm_seq_detect_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  output logic               y,
  output logic [STATE_W-1:0] ps1,
  output logic [STATE_W-1:0] ns1
);

  logic [STATE_W-1:0] ps;
  logic [STATE_W-1:0] ns;

  always_ff @(posedge clk) begin
    if (!rst) ps <= S0;
    else      ps <= ns;
  end

  // Codes 5..15 fall to the default and recover to idle.
  always_comb begin
    ns = S0;
    if (rst) begin
      unique case (ps)
        S0:      ns = x ? S1 : S0;
        S1:      ns = x ? S1 : S2;
        S2:      ns = x ? S3 : S0;
        S3:      ns = x ? S4 : S2;
        S4: begin
          if (x)            ns = S1;
          else if (OVERLAP) ns = S2;
          else              ns = S0;
        end
        default: ns = S0;
      endcase
    end
  end

  always_comb begin
    y = 1'b0;
    if (ps == S4) y = 1'b1;
  end

  assign ps1 = ps;
  assign ns1 = ns;

endmodule

// File: tb/tb_fsm_seq_detect.sv
// Directed bench for fsm_seq_detect, both overlap modes.
// Ports exercised: clk, rst, x, y, ps1, ns1.
module tb_fsm_seq_detect;
  import fsm_seq_detect_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       x;
  logic       y_a;
  logic       y_b;
  logic [3:0] ps_a;
  logic [3:0] ns_a;
  logic [3:0] ps_b;
  logic [3:0] ns_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsm_seq_detect #(.OVERLAP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .x(x),
    .y(y_a), .ps1(ps_a), .ns1(ns_a)
  );

  fsm_seq_detect #(.OVERLAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .x(x),
    .y(y_b), .ps1(ps_b), .ns1(ns_b)
  );

  task automatic do_reset();
    rst = 1'b0;
    x   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (ns_a !== 4'd0 || ns_b !== 4'd0) begin
        errors++;
        $display("FAIL reset_ns i=%0d got %0d/%0d exp 0",
                 i, ns_a, ns_b);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ps_a !== 4'd0 || ps_b !== 4'd0 ||
          y_a !== 1'b0 || y_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_ps i=%0d got ps %0d/%0d y %b/%b exp 0",
                 i, ps_a, ps_b, y_a, y_b);
      end
    end
    rst = 1'b1;
    x   = 1'b1;
    #1;
    checks++;
    if (ns_a !== 4'd1) begin
      errors++;
      $display("FAIL reset_rel_ns got %0d exp 1", ns_a);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ps_a !== 4'd1 || ps_b !== 4'd1) begin
      errors++;
      $display("FAIL reset_rel_ps got %0d/%0d exp 1", ps_a, ps_b);
    end
  endtask

  task automatic test_single_match();
    logic [3:0] pat;
    logic       xs [5];
    logic [3:0] ep [5];
    pat = PATTERN;
    xs  = '{pat[3], pat[2], pat[1], pat[0], 1'b0};
    ep  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd2};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      x = xs[i];
      #1;
      checks++;
      if (ns_a !== ep[i]) begin
        errors++;
        $display("FAIL single_ns i=%0d got %0d exp %0d",
                 i, ns_a, ep[i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ps_a !== ep[i] || y_a !== (ep[i] == 4'd4)) begin
        errors++;
        $display("FAIL single_ps i=%0d got %0d y=%b exp %0d",
                 i, ps_a, y_a, ep[i]);
      end
    end
  endtask

  task automatic test_overlap();
    logic       xs [7];
    logic [3:0] ea [7];
    logic [3:0] eb [7];
    int         na;
    int         nb;
    xs = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ea = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd2, 4'd3, 4'd4};
    eb = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd1};
    na = 0;
    nb = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      x = xs[i];
      @(posedge clk);
      #1;
      if (y_a === 1'b1) na++;
      if (y_b === 1'b1) nb++;
      checks++;
      if (ps_a !== ea[i] || ps_b !== eb[i]) begin
        errors++;
        $display("FAIL overlap_ps i=%0d got %0d/%0d exp %0d/%0d",
                 i, ps_a, ps_b, ea[i], eb[i]);
      end
    end
    checks++;
    if (na != 2 || nb != 1) begin
      errors++;
      $display("FAIL overlap_pulses got %0d/%0d exp 2/1", na, nb);
    end
  endtask

  task automatic test_near_miss();
    logic       xs [9];
    logic [3:0] ep [9];
    xs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
           1'b1, 1'b0, 1'b1, 1'b0};
    ep = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd0,
           4'd1, 4'd2, 4'd3, 4'd2};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      x = xs[i];
      @(posedge clk);
      #1;
      checks++;
      if (ps_a !== ep[i] || ps_b !== ep[i] ||
          y_a !== 1'b0 || y_b !== 1'b0) begin
        errors++;
        $display("FAIL near_ps i=%0d got %0d/%0d y %b/%b exp %0d",
                 i, ps_a, ps_b, y_a, y_b, ep[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic       xs [5];
    logic       rs [5];
    logic [3:0] ep [5];
    xs = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    rs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ep = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      x   = xs[i];
      rst = rs[i];
      @(posedge clk);
      #1;
      checks++;
      if (ps_a !== ep[i] || y_a !== 1'b0) begin
        errors++;
        $display("FAIL midrst_ps i=%0d got %0d y=%b exp %0d",
                 i, ps_a, y_a, ep[i]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_illegal();
    do_reset();
    x = 1'b0;
    force dut_a.ps = 4'd9;
    #1;
    checks++;
    if (ns_a !== 4'd0 || y_a !== 1'b0) begin
      errors++;
      $display("FAIL illegal_x0 got ns=%0d y=%b exp 0/0",
               ns_a, y_a);
    end
    x = 1'b1;
    #1;
    checks++;
    if (ns_a !== 4'd0 || y_a !== 1'b0) begin
      errors++;
      $display("FAIL illegal_x1 got ns=%0d y=%b exp 0/0",
               ns_a, y_a);
    end
    x = 1'b0;
    #1;
    release dut_a.ps;
    @(posedge clk);
    #1;
    checks++;
    if (ps_a !== 4'd0) begin
      errors++;
      $display("FAIL illegal_rec got %0d exp 0", ps_a);
    end
  endtask

  initial begin
    rst = 1'b0;
    x   = 1'b0;
    test_reset();
    test_single_match();
    test_overlap();
    test_near_miss();
    test_mid_reset();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
